// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with byte-lane writes, optional post-reset clear sweep.
// Latency: read data valid 1 + OUT_REG enabled cycles after accept; writes land at the accept edge.
// Backpressure: waitrequest during reset, the clear sweep, or clken=0; clken=0 freezes every stage.
module onchip_ram_pipelined #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic                      clken,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      init_done
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Without a clear sweep the block is usable straight out of reset.
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_d;
    logic                    clr_we;
    logic                    init_done_q;

    logic                    req_acc;
    logic                    wr_acc;
    logic                    rd_acc;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [NUM_LANES-1:0]    mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdat;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    rd1_vld_q;
    logic [DATA_WIDTH-1:0]   rd1_dat_q;
    logic                    rsp_vld;

    // Reset is folded in so the master sees a stall while reset_n is low,
    // even when the reset state is RUN.
    assign waitrequest = ~reset_n | (state_q == ST_CLEAR) | ~clken;

    // A combined read+write is treated as a write only.
    assign req_acc = chipselect & (read | write) & ~waitrequest;
    assign wr_acc  = req_acc & write;
    assign rd_acc  = req_acc & read & ~write;

    // Next-state logic: the sweep advances one word per enabled cycle and
    // hands over to RUN on the cycle that writes the last address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clken && reset_n) begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State, sweep counter and registered init_done; init_done tracks the
    // next state so it rises on the same edge the FSM enters RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= (state_d == ST_RUN);
        end
    end

    assign init_done = init_done_q;

    // Write-port mux: the sweep owns the port while clearing, the bus otherwise.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = address;
        mem_be   = byteenable;
        mem_wdat = writedata;
        if (clr_we) begin
            mem_we   = 1'b1;
            mem_addr = clr_cnt_q;
            mem_be   = '1;
            mem_wdat = CLEAR_VALUE;
        end else if (wr_acc) begin
            mem_we   = 1'b1;
        end
    end

    // Storage array: byte-lane writes, deliberately no reset so contents
    // survive a reset when the sweep is disabled.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][i*8 +: 8] <= mem_wdat[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: data only reloads on an accepted read so readdata
    // holds between responses; a write from the previous cycle is already
    // in the array, so no bypass is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_vld_q <= 1'b0;
            rd1_dat_q <= '0;
        end else if (clken) begin
            rd1_vld_q <= rd_acc;
            if (rd_acc) begin
                rd1_dat_q <= mem[address];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rd2_vld_q;
            logic [DATA_WIDTH-1:0] rd2_dat_q;

            // Optional output stage, frozen by clken like the rest of the pipe.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd2_vld_q <= 1'b0;
                    rd2_dat_q <= '0;
                end else if (clken) begin
                    rd2_vld_q <= rd1_vld_q;
                    if (rd1_vld_q) begin
                        rd2_dat_q <= rd1_dat_q;
                    end
                end
            end

            assign readdata = rd2_dat_q;
            assign rsp_vld  = rd2_vld_q;
        end else begin : g_no_out_reg
            assign readdata = rd1_dat_q;
            assign rsp_vld  = rd1_vld_q;
        end
    endgenerate

    // A response held across a stall is masked until clken returns, so it
    // is presented exactly once.
    assign readdatavalid = rsp_vld & clken;

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Directed bench for onchip_ram_pipelined: two instances share all inputs.
// Instance a: defaults (sweep on reset, latency 1); instance b: OUT_REG=1, no sweep (latency 2).
// Inputs driven 1 time unit after the rising edge, outputs checked 2 units after it.
module tb_onchip_ram_pipelined;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;

    logic [31:0] a_readdata;
    logic        a_readdatavalid;
    logic        a_waitrequest;
    logic        a_init_done;
    logic [31:0] b_readdata;
    logic        b_readdatavalid;
    logic        b_waitrequest;
    logic        b_init_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onchip_ram_pipelined dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .readdata      (a_readdata),
        .readdatavalid (a_readdatavalid),
        .waitrequest   (a_waitrequest),
        .init_done     (a_init_done)
    );

    onchip_ram_pipelined #(
        .OUT_REG        (1),
        .CLEAR_ON_RESET (0)
    ) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .readdata      (b_readdata),
        .readdatavalid (b_readdatavalid),
        .waitrequest   (b_waitrequest),
        .init_done     (b_init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic cs, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d, input logic ce);
        @(posedge clk);
        #1;
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = d;
        clken      = ce;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    endtask

    initial begin
        int   wr_hi;
        int   early_done;
        logic b_init_first;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        clken      = 1'b1;
        #2;

        // Reset state.
        chk("rst_a_readdata",      a_readdata,      32'h0);
        chk("rst_a_readdatavalid", a_readdatavalid, 32'h0);
        chk("rst_a_init_done",     a_init_done,     32'h0);
        chk("rst_a_waitrequest",   a_waitrequest,   32'h1);
        chk("rst_b_waitrequest",   b_waitrequest,   32'h1);
        chk("rst_b_init_done",     b_init_done,     32'h0);

        // First release: b is usable at once, a starts sweeping.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rel_b_init_pre",  b_init_done,   32'h0);
        chk("rel_a_wait",      a_waitrequest, 32'h1);
        chk("rel_b_wait",      b_waitrequest, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 12'h009, 4'hF, 32'h0000_0099, 1'b1);
        chk("rel_b_init_post", b_init_done,   32'h1);
        issue(1'b1, 1'b1, 1'b0, 12'h009, 4'h0, 32'h0, 1'b1);
        idle();
        chk("p1_a_no_rsp", a_readdatavalid, 32'h0);
        idle();
        chk("p1_b_rdv", b_readdatavalid, 32'h1);
        chk("p1_b_rd",  b_readdata,      32'h0000_0099);

        // Let a's sweep reach address 100, then pulse reset mid-cycle.
        for (int i = 0; i < 96; i++) begin
            idle();
        end
        reset_n = 1'b0;
        #1;
        chk("mid_a_readdata",    a_readdata,      32'h0);
        chk("mid_a_rdv",         a_readdatavalid, 32'h0);
        chk("mid_a_init_done",   a_init_done,     32'h0);
        chk("mid_a_waitrequest", a_waitrequest,   32'h1);
        chk("mid_b_readdata",    b_readdata,      32'h0);
        chk("mid_b_init_done",   b_init_done,     32'h0);
        chk("mid_b_waitrequest", b_waitrequest,   32'h1);

        // Second release: the sweep must restart and take 4096 enabled cycles.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        wr_hi        = 0;
        early_done   = 0;
        b_init_first = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            if (a_waitrequest) wr_hi++;
            if (a_init_done) early_done++;
            if (i == 1) b_init_first = b_init_done;
            idle();
        end
        chk("sweep_wait_cycles", wr_hi,         32'd4096);
        chk("sweep_early_done",  early_done,    32'd0);
        chk("sweep_a_init_done", a_init_done,   32'h1);
        chk("sweep_a_wait_low",  a_waitrequest, 32'h0);
        chk("b_init_first_edge", b_init_first,  32'h1);

        // Address 9: cleared in a (its early write was refused), survived in b.
        issue(1'b1, 1'b1, 1'b0, 12'h009, 4'h0, 32'h0, 1'b1);
        idle();
        chk("surv_a_rdv", a_readdatavalid, 32'h1);
        chk("surv_a_rd",  a_readdata,      32'h0);
        idle();
        chk("surv_b_rdv", b_readdatavalid, 32'h1);
        chk("surv_b_rd",  b_readdata,      32'h0000_0099);

        // Read of a swept address.
        issue(1'b1, 1'b1, 1'b0, 12'hABC, 4'h0, 32'h0, 1'b1);
        chk("abc_accept", a_waitrequest, 32'h0);
        idle();
        chk("abc_a_rdv",   a_readdatavalid, 32'h1);
        chk("abc_a_rd",    a_readdata,      32'h0);
        chk("abc_b_early", b_readdatavalid, 32'h0);
        idle();
        chk("abc_a_once",  a_readdatavalid, 32'h0);
        chk("abc_b_rdv",   b_readdatavalid, 32'h1);

        // Byte-lane merge, read issued right after the last write.
        issue(1'b1, 1'b0, 1'b1, 12'h005, 4'hF, 32'h1122_3344, 1'b1);
        issue(1'b1, 1'b0, 1'b1, 12'h005, 4'h5, 32'hAABB_CCDD, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 12'h005, 4'h0, 32'h0, 1'b1);
        idle();
        chk("be_a_rdv", a_readdatavalid, 32'h1);
        chk("be_a_rd",  a_readdata,      32'h11BB_33DD);
        idle();
        chk("be_b_rdv", b_readdatavalid, 32'h1);
        chk("be_b_rd",  b_readdata,      32'h11BB_33DD);

        // chipselect low: the write must be ignored.
        issue(1'b0, 1'b0, 1'b1, 12'h005, 4'hF, 32'h0000_0000, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 12'h005, 4'h0, 32'h0, 1'b1);
        idle();
        chk("ncs_a_rd", a_readdata, 32'h11BB_33DD);
        idle();
        chk("ncs_b_rd", b_readdata, 32'h11BB_33DD);

        // Back-to-back reads of 1,2,3.
        issue(1'b1, 1'b0, 1'b1, 12'h001, 4'hF, 32'h0000_000A, 1'b1);
        issue(1'b1, 1'b0, 1'b1, 12'h002, 4'hF, 32'h0000_000B, 1'b1);
        issue(1'b1, 1'b0, 1'b1, 12'h003, 4'hF, 32'h0000_000C, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 12'h001, 4'h0, 32'h0, 1'b1);
        chk("b2b_b_none", b_readdatavalid, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 12'h002, 4'h0, 32'h0, 1'b1);
        chk("b2b_a_rd1",  a_readdata,      32'h0000_000A);
        chk("b2b_b_c1",   b_readdatavalid, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 12'h003, 4'h0, 32'h0, 1'b1);
        chk("b2b_a_rd2",  a_readdata,      32'h0000_000B);
        chk("b2b_b_rdv2", b_readdatavalid, 32'h1);
        chk("b2b_b_rd2",  b_readdata,      32'h0000_000A);
        idle();
        chk("b2b_a_rd3",  a_readdata,      32'h0000_000C);
        chk("b2b_b_rdv3", b_readdatavalid, 32'h1);
        chk("b2b_b_rd3",  b_readdata,      32'h0000_000B);
        idle();
        chk("b2b_a_end",  a_readdatavalid, 32'h0);
        chk("b2b_b_rdv4", b_readdatavalid, 32'h1);
        chk("b2b_b_rd4",  b_readdata,      32'h0000_000C);
        idle();
        chk("b2b_b_end",  b_readdatavalid, 32'h0);
        chk("b2b_b_hold", b_readdata,      32'h0000_000C);

        // Read of 2 followed by a 3-cycle clken stall.
        issue(1'b1, 1'b1, 1'b0, 12'h002, 4'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b0);
            chk("stall_a_rdv",  a_readdatavalid, 32'h0);
            chk("stall_b_rdv",  b_readdatavalid, 32'h0);
            chk("stall_a_wait", a_waitrequest,   32'h1);
        end
        idle();
        chk("stall_a_out",    a_readdatavalid, 32'h1);
        chk("stall_a_rd",     a_readdata,      32'h0000_000B);
        chk("stall_b_notyet", b_readdatavalid, 32'h0);
        idle();
        chk("stall_b_out",    b_readdatavalid, 32'h1);
        chk("stall_b_rd",     b_readdata,      32'h0000_000B);
        chk("stall_a_once",   a_readdatavalid, 32'h0);
        idle();
        chk("stall_b_once",   b_readdatavalid, 32'h0);

        // Combined read+write: write only, no response.
        issue(1'b1, 1'b1, 1'b1, 12'h007, 4'hF, 32'h0000_0005, 1'b1);
        idle();
        chk("rw_a_none", a_readdatavalid, 32'h0);
        idle();
        chk("rw_b_none", b_readdatavalid, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 12'h007, 4'h0, 32'h0, 1'b1);
        idle();
        chk("rw_a_rdv", a_readdatavalid, 32'h1);
        chk("rw_a_rd",  a_readdata,      32'h0000_0005);
        idle();
        chk("rw_b_rdv", b_readdatavalid, 32'h1);
        chk("rw_b_rd",  b_readdata,      32'h0000_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
